// File: rtl/debounce_pkg.sv
// Shared types and default sizes for the switch/button debounce stage.
// Optional build macro: BTN_DEBOUNCE_FALL_TICK_EN (tick also marks debounced falls).
package debounce_pkg;

  localparam int unsigned DB_WIDTH_DEF    = 10;
  localparam int unsigned DB_CNT_BITS_DEF = 20;

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    WAIT1   = 2'd1,
    STABLE1 = 2'd2,
    WAIT0   = 2'd3
  } db_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchronizer, settle FSM, window counter, tick register.
// BTN_DEBOUNCE_FALL_TICK_EN makes the WAIT0 timeout pulse tick as well.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_BITS = DB_CNT_BITS_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_i,
  output logic db_o,
  output logic tick_o
);

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

`ifdef BTN_DEBOUNCE_FALL_TICK_EN
  localparam logic FALL_TICK = 1'b1;
`else
  localparam logic FALL_TICK = 1'b0;
`endif

  logic [1:0]          sync_q;
  db_state_e           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                db_q, db_d;
  logic                tick_q, tick_d;
  logic                s;

  assign s = sync_q[1];

  // Next state: a WAIT state must see the new level for the full window before committing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    tick_d  = 1'b0;
    case (state_q)
      STABLE0: begin
        db_d = 1'b0;
        if (s) begin
          state_d = WAIT1;
          cnt_d   = '0;
        end
      end
      WAIT1: begin
        if (!s) begin
          state_d = STABLE0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE1;
          db_d    = 1'b1;
          tick_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      STABLE1: begin
        db_d = 1'b1;
        if (!s) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
      end
      WAIT0: begin
        if (s) begin
          state_d = STABLE1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE0;
          db_d    = 1'b0;
          tick_d  = FALL_TICK;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: begin
        state_d = STABLE0;
        cnt_d   = '0;
        db_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 2'b00;
      state_q <= STABLE0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      tick_q  <= tick_d;
    end
  end

  assign db_o   = db_q;
  assign tick_o = tick_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounces WIDTH raw switch/button inputs into clean levels plus press ticks.
// Build option BTN_DEBOUNCE_FALL_TICK_EN: ticks also mark debounced releases.
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH    = DB_WIDTH_DEF,
  parameter int unsigned CNT_BITS = DB_CNT_BITS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] db,
  output logic [WIDTH-1:0] tick
);

  // Channels are fully independent; each keeps its own window.
  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_ch #(
      .CNT_BITS (CNT_BITS)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .raw_i   (raw[g]),
      .db_o    (db[g]),
      .tick_o  (tick[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed plus random stimulus for btn_debounce, checked every cycle against a
// run-length reference model (WIDTH=10, CNT_BITS=4).
module tb_btn_debounce;

  localparam int unsigned W   = 10;
  localparam int unsigned CB  = 4;
  localparam int          WIN = (1 << CB) + 1;

`ifdef BTN_DEBOUNCE_FALL_TICK_EN
  localparam logic FALL_TICK = 1'b1;
`else
  localparam logic FALL_TICK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] raw;
  logic [W-1:0] db;
  logic [W-1:0] tick;

  int checks   = 0;
  int failures = 0;

  // Reference: s is raw delayed two edges; db flips once s has differed from db
  // on WIN consecutive edges.
  logic [W-1:0] m_r1, m_s, m_db, m_tick;
  int           run [W];

  btn_debounce #(
    .WIDTH    (W),
    .CNT_BITS (CB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (raw),
    .db      (db),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_r1   = '0;
    m_s    = '0;
    m_db   = '0;
    m_tick = '0;
    for (int i = 0; i < int'(W); i++) run[i] = 0;
  endtask

  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < int'(W); i++) begin
      m_tick[i] = 1'b0;
      if (m_s[i] != m_db[i]) begin
        run[i]++;
        if (run[i] == WIN) begin
          m_db[i]   = m_s[i];
          m_tick[i] = m_s[i] | FALL_TICK;
          run[i]    = 0;
        end
      end else begin
        run[i] = 0;
      end
      m_s[i]  = m_r1[i];
      m_r1[i] = raw[i];
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("model_db", db, m_db);
      chk("model_tick", tick, m_tick);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    raw     = 10'h3FF;
    model_reset();
    #1;
    chk("reset_db", db, 10'h000);
    chk("reset_tick", tick, 10'h000);
    step(3);
    chk("reset_hold_db", db, 10'h000);

    // Release with all inputs high: debounced afresh.
    reset_n = 1'b1;
    step(18);
    chk("rel_db_edge18", db, 10'h000);
    step(1);
    chk("rel_db_edge19", db, 10'h3FF);
    chk("rel_tick_edge19", tick, 10'h3FF);
    step(1);
    chk("rel_tick_edge20", tick, 10'h000);

    // Everything back low.
    raw = 10'h000;
    step(18);
    chk("all_fall_pre", db, 10'h3FF);
    step(1);
    chk("all_fall_db", db, 10'h000);
    chk("all_fall_tick", tick, FALL_TICK ? 10'h3FF : 10'h000);
    step(2);

    // Clean press on channel 8.
    raw[8] = 1'b1;
    step(18);
    chk("press_pre", db, 10'h000);
    step(1);
    chk("press_db", db, 10'h100);
    chk("press_tick", tick, 10'h100);
    step(1);
    chk("press_tick_off", tick, 10'h000);

    // Bounce on channel 0: 1,0,1,0 each 3 cycles, then hold 1.
    for (int b = 0; b < 4; b++) begin
      raw[0] = ~raw[0];
      step(3);
      chk("bounce_db", db, 10'h100);
    end
    raw[0] = 1'b1;
    step(18);
    chk("bounce_pre", db, 10'h100);
    step(1);
    chk("bounce_db_final", db, 10'h101);
    chk("bounce_tick", tick, 10'h001);

    // Release of channel 8.
    raw[8] = 1'b0;
    step(18);
    chk("release_pre", db, 10'h101);
    step(1);
    chk("release_db", db, 10'h001);
    chk("release_tick", tick, FALL_TICK ? 10'h100 : 10'h000);
    step(2);

    // Reset mid-count on channel 3; channel 0 held high is also re-debounced.
    raw[3] = 1'b1;
    step(9);
    reset_n = 1'b0;
    model_reset();
    step(1);
    chk("midrst_db", db, 10'h000);
    chk("midrst_tick", tick, 10'h000);
    reset_n = 1'b1;
    step(18);
    chk("midrst_pre", db, 10'h000);
    step(1);
    chk("midrst_db_final", db, 10'h009);
    chk("midrst_tick_final", tick, 10'h009);

    // Channels 1 and 2 together; channel 2 glitches low at edge 8.
    raw[1] = 1'b1;
    raw[2] = 1'b1;
    step(7);
    raw[2] = 1'b0;
    step(1);
    raw[2] = 1'b1;
    step(10);
    chk("simul_pre", db, 10'h009);
    step(1);
    chk("simul_db1", db, 10'h00B);
    chk("simul_tick1", tick, 10'h002);
    step(7);
    chk("simul_db2_pre", db, 10'h00B);
    step(1);
    chk("simul_db2", db, 10'h00F);
    chk("simul_tick2", tick, 10'h004);

    // Random bouncing inputs with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(W); i++)
        if ($urandom_range(39) == 0) raw[i] = ~raw[i];
      if ($urandom_range(999) == 0) begin
        reset_n = 1'b0;
        model_reset();
        step(1);
        reset_n = 1'b1;
      end
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
